// File: rtl/psum_acc_relu_if.sv
// rtl/psum_acc_relu_if.sv - input/output vector handshakes and group config for psum_acc_relu
interface psum_acc_relu_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [3:0]             taps;
  logic                   act_en;
  logic [psum_bw*col-1:0] in_data;
  logic                   in_valid;
  logic                   in_rd;
  logic [psum_bw*col-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output taps, act_en, in_data, in_valid, out_ready,
    input  in_rd, out_data, out_valid, busy
  );

  modport slave (
    input  taps, act_en, in_data, in_valid, out_ready,
    output in_rd, out_data, out_valid, busy
  );
endinterface

// File: rtl/psum_acc_relu.sv
// rtl/psum_acc_relu.sv - per-lane accumulation of taps vectors, saturation and optional ReLU
module psum_acc_relu #(
  parameter int col     = 8,
  parameter int psum_bw = 16
) (
  input logic           clk,
  input logic           reset,
  psum_acc_relu_if.slave bus
);
  localparam int aw = psum_bw + 4;
  localparam logic signed [aw-1:0] sat_hi = {{(aw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
  localparam logic signed [aw-1:0] sat_lo = {{(aw-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [3:0]             taps_q;
  logic [3:0]             cnt;
  logic                   act_q;
  logic [psum_bw*col-1:0] out_q;

  logic                   rd;
  logic                   beat;
  logic [3:0]             taps_eff;
  logic [3:0]             cnt_nx;
  logic                   last;
  logic                   act_use;
  logic                   load;
  logic [psum_bw*col-1:0] out_nx;

  assign rd       = (state != HOLD);
  assign beat     = bus.in_valid && rd;
  assign taps_eff = (bus.taps == 4'd0) ? 4'd1 : bus.taps;
  assign cnt_nx   = (state == IDLE) ? 4'd1 : cnt + 4'd1;
  // Group config comes from the live inputs on the first beat, from the latched copy afterwards
  assign last     = (state == IDLE) ? (taps_eff == 4'd1) : (cnt_nx == taps_q);
  assign act_use  = (state == IDLE) ? bus.act_en : act_q;
  assign load     = beat && last;

  for (genvar k = 0; k < col; k++) begin : g_lane
    logic signed [aw-1:0]      acc;
    logic signed [aw-1:0]      ext;
    logic signed [aw-1:0]      sum_nx;
    logic signed [psum_bw-1:0] sat;

    assign ext    = {{(aw-psum_bw){bus.in_data[psum_bw*(k+1)-1]}}, bus.in_data[psum_bw*k +: psum_bw]};
    assign sum_nx = ((state == IDLE) ? '0 : acc) + ext;
    assign sat    = (sum_nx > sat_hi) ? sat_hi[psum_bw-1:0] :
                    (sum_nx < sat_lo) ? sat_lo[psum_bw-1:0] : sum_nx[psum_bw-1:0];
    assign out_nx[psum_bw*k +: psum_bw] = (act_use && sat[psum_bw-1]) ? '0 : sat;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc <= '0;
      end else if (beat) begin
        acc <= sum_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (beat) state_nx = last ? HOLD : ACC;
      ACC:     if (load) state_nx = HOLD;
      HOLD:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps_q <= 4'd0;
      act_q  <= 1'b0;
      cnt    <= 4'd0;
      out_q  <= '0;
    end else begin
      if (beat) begin
        cnt <= cnt_nx;
      end
      if (beat && (state == IDLE)) begin
        taps_q <= taps_eff;
        act_q  <= bus.act_en;
      end
      if (load) begin
        out_q <= out_nx;
      end
    end
  end

  assign bus.in_rd     = !reset && rd;
  assign bus.out_data  = out_q;
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_psum_acc_relu.sv
// tb/tb_psum_acc_relu.sv - self-checking bench for psum_acc_relu against an arithmetic group model
module tb_psum_acc_relu;
  localparam int col = 8;
  localparam int pbw = 16;

  logic clk = 1'b0;
  logic reset;

  psum_acc_relu_if #(.col(col), .psum_bw(pbw)) bus ();

  psum_acc_relu #(.col(col), .psum_bw(pbw)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int beats [15][8];
  logic [pbw*col-1:0] last_out;

  always @(posedge clk) begin
    if (!reset && bus.in_valid && bus.in_rd) pops++;
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [pbw*col-1:0] obs, input logic [pbw*col-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [pbw*col-1:0] pack(input int b);
    logic [pbw*col-1:0] v;
    for (int k = 0; k < col; k++) v[pbw*k +: pbw] = pbw'(beats[b][k]);
    return v;
  endfunction

  // Reference: clip the exact integer sum to the signed lane range, then ReLU
  function automatic logic [pbw-1:0] model_lane(input int s, input bit act);
    int r;
    r = s;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (act && r < 0) r = 0;
    return pbw'(r);
  endfunction

  task automatic clear_beats();
    for (int b = 0; b < 15; b++)
      for (int k = 0; k < col; k++) beats[b][k] = 0;
  endtask

  task automatic random_beats(input bit wide);
    logic signed [15:0] tmp;
    for (int b = 0; b < 15; b++)
      for (int k = 0; k < col; k++) begin
        tmp = 16'($urandom);
        beats[b][k] = wide ? int'(tmp) : int'($urandom_range(0, 200)) - 100;
      end
  endtask

  // mode 0: back-to-back beats, 1: valid pattern 1,0,0,1,0,1, 2: random gaps
  task automatic run_group(input int t, input bit act, input int mode);
    int n;
    int gaps;
    int sums [8];
    logic [pbw*col-1:0] exp;
    n = (t == 0) ? 1 : t;
    for (int k = 0; k < col; k++) sums[k] = 0;
    for (int b = 0; b < n; b++) begin
      gaps = (mode == 1) ? ((b == 1) ? 2 : (b == 2) ? 1 : 0) :
             (mode == 2) ? int'($urandom_range(0, 1)) : 0;
      repeat (gaps) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.taps     = 4'($urandom);
        bus.act_en   = 1'($urandom);
      end
      @(negedge clk);
      bus.taps     = (b == 0) ? 4'(t) : 4'($urandom);
      bus.act_en   = (b == 0) ? act : 1'($urandom);
      bus.in_data  = pack(b);
      bus.in_valid = 1'b1;
      check1("in_rd_open", bus.in_rd, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int k = 0; k < col; k++) sums[k] += beats[b][k];
      if (b < n - 1) begin
        check1("out_valid_mid_group", bus.out_valid, 1'b0);
        check1("busy_mid_group", bus.busy, 1'b1);
      end
    end
    for (int k = 0; k < col; k++) exp[pbw*k +: pbw] = model_lane(sums[k], act);
    check1("out_valid_on_last_beat", bus.out_valid, 1'b1);
    check1("in_rd_low_in_hold", bus.in_rd, 1'b0);
    check1("busy_in_hold", bus.busy, 1'b1);
    checkv("out_data", bus.out_data, exp);
    last_out = bus.out_data;
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check1("out_valid_after_hs", bus.out_valid, 1'b0);
    check1("busy_after_hs", bus.busy, 1'b0);
    checkv("out_data_kept", bus.out_data, last_out);
    @(negedge clk);
    check1("in_rd_after_hs", bus.in_rd, 1'b1);
  endtask

  initial begin
    int p0;
    reset         = 1'b1;
    bus.taps      = 4'd0;
    bus.act_en    = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_in_rd", bus.in_rd, 1'b0);
    checkv("rst_out_data", bus.out_data, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    clear_beats();
    beats[0][0] = 100; beats[1][0] = -20; beats[2][0] = 5;
    beats[0][7] = 1;   beats[1][7] = 1;   beats[2][7] = 1;
    run_group(3, 1'b0, 0);
    checkv("basic_lane0_85", 128'(bus.out_data[15:0]), 128'(85));
    checkv("basic_lane7_3", 128'(bus.out_data[127:112]), 128'(3));
    handshake();

    // abort a taps=4 group after two beats
    random_beats(1'b1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus.taps     = 4'd4;
      bus.in_data  = pack(b);
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check1("midrst_out_valid", bus.out_valid, 1'b0);
    check1("midrst_busy", bus.busy, 1'b0);
    check1("midrst_in_rd", bus.in_rd, 1'b0);
    checkv("midrst_out_data", bus.out_data, '0);
    @(negedge clk);
    reset = 1'b0;
    clear_beats();
    beats[0][0] = 7;
    run_group(1, 1'b0, 0);
    checkv("after_rst_lane0_7", 128'(bus.out_data[15:0]), 128'(7));
    handshake();

    clear_beats();
    for (int b = 0; b < 4; b++) for (int k = 0; k < col; k++) beats[b][k] = 28672;
    run_group(4, 1'b0, 0);
    checkv("sat_pos", bus.out_data, {8{16'h7fff}});
    handshake();
    for (int b = 0; b < 2; b++) for (int k = 0; k < col; k++) beats[b][k] = -30000;
    run_group(2, 1'b0, 0);
    checkv("sat_neg", bus.out_data, {8{16'h8000}});
    handshake();

    clear_beats();
    beats[0][0] = -5; beats[1][0] = 3;
    beats[0][1] = 10; beats[1][1] = 4;
    run_group(2, 1'b1, 0);
    checkv("relu_lane0", 128'(bus.out_data[15:0]), 128'(0));
    checkv("relu_lane1", 128'(bus.out_data[31:16]), 128'(14));
    handshake();
    run_group(2, 1'b0, 0);
    checkv("norelu_lane0", 128'(bus.out_data[15:0]), 128'(16'hfffe));
    handshake();

    // backpressure: stalled output must not pop the upstream FIFO
    random_beats(1'b1);
    run_group(2, 1'b0, 0);
    p0 = pops;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check1("bp_out_valid", bus.out_valid, 1'b1);
      check1("bp_in_rd", bus.in_rd, 1'b0);
      checkv("bp_out_data", bus.out_data, last_out);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check1("bp_hs_out_valid", bus.out_valid, 1'b0);
    checkv("bp_no_pops", 128'(pops - p0), 128'(0));
    check1("bp_in_rd_after", bus.in_rd, 1'b1);

    for (int g = 0; g < 3; g++) begin
      random_beats(1'b1);
      run_group(0, 1'($urandom), 0);
      handshake();
    end

    random_beats(1'b0);
    run_group(3, 1'b0, 1);
    handshake();

    for (int g = 0; g < 12; g++) begin
      random_beats(1'($urandom));
      run_group(int'($urandom_range(0, 15)), 1'($urandom), 2);
      handshake();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
